button_event_decoder: RTL

- Consumer end of the debounced-button interface: takes the clean, active-high pressed level from the debouncer.
- Classifies each gesture into one of four event types: short press, long press, double click, auto-repeat while held.
- Each event is a registered single-cycle pulse.
- Sits between the push-button debouncers and the game/menu control FSM, so downstream logic never times button levels itself.

---
 rtl/button_event_decoder_pkg.sv | 31 +++
 rtl/button_event_decoder_tick_timer.sv | 28 ++
 rtl/button_event_decoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared UI timing constants and button gesture FSM encoding.
// Used by the debouncers, the event decoder and the menu logic.
package button_event_decoder_pkg;

  localparam int CLK_HZ = 50_000_000;

  localparam int LONG_TICKS_DEF     = CLK_HZ / 2;
  localparam int DCLICK_TICKS_DEF   = CLK_HZ / 4;
  localparam int REPEAT_TICKS_DEF   = CLK_HZ / 10;
  localparam int DEBOUNCE_TICKS_DEF = CLK_HZ / 100;
  localparam int CNT_W_DEF          = 25;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS1    = 3'd1;
  localparam logic [2:0] ST_WAIT2     = 3'd2;
  localparam logic [2:0] ST_PRESS2    = 3'd3;
  localparam logic [2:0] ST_LONG_HOLD = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    PRESS1    = ST_PRESS1,
    WAIT2     = ST_WAIT2,
    PRESS2    = ST_PRESS2,
    LONG_HOLD = ST_LONG_HOLD
  } btn_state_t;

  function automatic int cnt_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/button_event_decoder_tick_timer.sv
// Clearable up-counter with a terminal compare against a limit.
// One instance serves the long, double-click and repeat timeouts.
module button_event_decoder_tick_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done_o = (cnt_q == limit_i);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into short, long, double-click
// and auto-repeat single-cycle event pulses.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int DCLICK_TICKS = DCLICK_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_level,
  input  logic       repeat_en,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       double_pulse,
  output logic       repeat_pulse,
  output logic       busy,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] LONG_LIM =
    CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLK_LIM =
    CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LIM =
    CNT_W'(REPEAT_TICKS - 1);

  btn_state_t state_q;
  logic btn_q;
  logic rise, fall;
  logic short_q, long_q, dbl_q, rep_q, busy_q;
  logic tmr_clr, tmr_done;
  logic [CNT_W-1:0] tmr_lim;

  // btn_q starts high so a button held through reset is ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn_level;
    end
  end

  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;

  always_comb begin
    tmr_lim = LONG_LIM;
    unique case (state_q)
      WAIT2:     tmr_lim = DCLK_LIM;
      LONG_HOLD: tmr_lim = REP_LIM;
      default:   tmr_lim = LONG_LIM;
    endcase
  end

  // Every edge or expiry is a transition or a repeat restart
  assign tmr_clr = (state_q == IDLE) | rise | fall
                 | tmr_done
                 | ((state_q == LONG_HOLD) & ~repeat_en);

  button_event_decoder_tick_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (tmr_clr),
    .en_i    (1'b1),
    .limit_i (tmr_lim),
    .done_o  (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      rep_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= PRESS1;
            busy_q  <= 1'b1;
          end
        end
        PRESS1: begin
          if (fall) begin
            state_q <= WAIT2;
          end else if (tmr_done) begin
            state_q <= LONG_HOLD;
            long_q  <= 1'b1;
          end
        end
        WAIT2: begin
          if (rise) begin
            state_q <= PRESS2;
          end else if (tmr_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            short_q <= 1'b1;
          end
        end
        PRESS2: begin
          if (fall) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            dbl_q   <= 1'b1;
          end else if (tmr_done) begin
            state_q <= LONG_HOLD;
            long_q  <= 1'b1;
          end
        end
        LONG_HOLD: begin
          if (fall) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (repeat_en && tmr_done) begin
            rep_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign double_pulse = dbl_q;
  assign repeat_pulse = rep_q;
  assign busy         = busy_q;
  assign state_o      = state_q;

endmodule
